// File: rtl/ex_alu_pkg.sv
// Shared opcode and sequencer-state types for the EX-stage ALU and its vector sequencer.
package ex_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_RELU   = 4'h8,
        ALU_MATMUL = 4'h9,
        ALU_VECADD = 4'hA,
        ALU_MPOOL  = 4'hB
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h8, 4'h9, 4'hA, 4'hB: legal = 1'b1;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ex_alu_sequencer_scratch.sv
// ex_scratch_ram: DEPTHx32 register file, three async read ports, one sync write port.
module ex_scratch_ram
    import ex_alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    input  logic [AW-1:0] raddr_h_i,
    output logic [31:0]   rdata_a_o,
    output logic [31:0]   rdata_b_o,
    output logic [31:0]   rdata_h_o
);

    logic [31:0] mem_q [DEPTH];

    // Storage has no reset so tile data survives a controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
    assign rdata_h_o = mem_q[raddr_h_i];

endmodule

// File: rtl/ex_alu_sequencer.sv
// Vector sequencer driving the EX-stage ALU over a local scratchpad, one element per cycle.
// Optional perf counters (perf_elems, perf_cmds) are built when EX_SEQ_PERF_EN is defined.
module ex_alu_sequencer
    import ex_alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int LEN_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_src_a,
    input  logic [AW-1:0]    cmd_src_b,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_use_imm,
    input  logic [31:0]      cmd_imm,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [31:0]      ld_data,
    output logic [31:0]      rd_data,
    output logic [31:0]      alu_rs1_val,
    output logic [31:0]      alu_rs2_val,
    output logic             alu_use_imm,
    output logic [31:0]      alu_imm,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef EX_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_elems,
    output logic [31:0]      perf_cmds
`endif
);

    seq_state_e       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [AW-1:0]    src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
    logic             use_imm_q, use_imm_d;
    logic [31:0]      imm_q, imm_d;
    logic             err_q, err_d;
    logic [31:0]      alu_rs1_q, alu_rs1_d, alu_rs2_q, alu_rs2_d, alu_imm_q, alu_imm_d;
    logic             alu_use_imm_q, alu_use_imm_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;

    logic             run_s;
    logic [AW-1:0]    addr_a_s, addr_b_s;
    logic [31:0]      rd_a_s, rd_b_s;
    logic             ram_we_s;
    logic [AW-1:0]    ram_waddr_s;
    logic [31:0]      ram_wdata_s;

    assign run_s    = (state_q == RUN);
    assign addr_a_s = src_a_q + idx_q[AW-1:0];
    assign addr_b_s = src_b_q + idx_q[AW-1:0];

    ex_scratch_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we_s),
        .waddr_i   (ram_waddr_s),
        .wdata_i   (ram_wdata_s),
        .raddr_a_i (addr_a_s),
        .raddr_b_i (addr_b_s),
        .raddr_h_i (ld_addr),
        .rdata_a_o (rd_a_s),
        .rdata_b_o (rd_b_s),
        .rdata_h_o (rd_data)
    );

    // Next-state, command latch and scratchpad write-port arbitration.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        dst_d         = dst_q;
        len_d         = len_q;
        use_imm_d     = use_imm_q;
        imm_d         = imm_q;
        idx_d         = idx_q;
        err_d         = err_q;
        alu_rs1_d     = alu_rs1_q;
        alu_rs2_d     = alu_rs2_q;
        alu_imm_d     = alu_imm_q;
        alu_use_imm_d = alu_use_imm_q;
        alu_ctrl_d    = alu_ctrl_q;
        ram_we_s      = 1'b0;
        ram_waddr_s   = ld_addr;
        ram_wdata_s   = ld_data;
        case (state_q)
            IDLE: begin
                ram_we_s = ld_we;
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    src_a_d   = cmd_src_a;
                    src_b_d   = cmd_src_b;
                    dst_d     = cmd_dst;
                    len_d     = cmd_len;
                    use_imm_d = cmd_use_imm;
                    imm_d     = cmd_imm;
                    idx_d     = '0;
                    err_d     = !is_legal_op(cmd_op);
                    if (!is_legal_op(cmd_op)) begin
                        state_d = FIN;
                    end else if (cmd_len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Result lands at the same edge the index advances, so element i+1 sees it.
                ram_we_s      = 1'b1;
                ram_waddr_s   = dst_q + idx_q[AW-1:0];
                ram_wdata_s   = alu_result;
                alu_rs1_d     = rd_a_s;
                alu_rs2_d     = rd_b_s;
                alu_imm_d     = imm_q;
                alu_use_imm_d = use_imm_q;
                alu_ctrl_d    = op_q;
                idx_d         = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command and held-ALU-operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= 4'h0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            use_imm_q     <= 1'b0;
            imm_q         <= 32'h0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            alu_rs1_q     <= 32'h0;
            alu_rs2_q     <= 32'h0;
            alu_imm_q     <= 32'h0;
            alu_use_imm_q <= 1'b0;
            alu_ctrl_q    <= 4'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            use_imm_q     <= use_imm_d;
            imm_q         <= imm_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            alu_rs1_q     <= alu_rs1_d;
            alu_rs2_q     <= alu_rs2_d;
            alu_imm_q     <= alu_imm_d;
            alu_use_imm_q <= alu_use_imm_d;
            alu_ctrl_q    <= alu_ctrl_d;
        end
    end

    // During RUN the ALU sees live scratchpad reads; otherwise the last driven values hold.
    assign alu_rs1_val = run_s ? rd_a_s    : alu_rs1_q;
    assign alu_rs2_val = run_s ? rd_b_s    : alu_rs2_q;
    assign alu_imm     = run_s ? imm_q     : alu_imm_q;
    assign alu_use_imm = run_s ? use_imm_q : alu_use_imm_q;
    assign alu_ctrl    = run_s ? op_q      : alu_ctrl_q;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = run_s;
    assign done      = (state_q == FIN);
    assign err       = err_q;

`ifdef EX_SEQ_PERF_EN
    logic [31:0] perf_elems_q, perf_cmds_q;

    // Saturating element-write and completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_elems_q <= 32'h0;
            perf_cmds_q  <= 32'h0;
        end else begin
            if (run_s && (perf_elems_q != 32'hFFFF_FFFF)) begin
                perf_elems_q <= perf_elems_q + 32'd1;
            end
            if (done && (perf_cmds_q != 32'hFFFF_FFFF)) begin
                perf_cmds_q <= perf_cmds_q + 32'd1;
            end
        end
    end

    assign perf_elems = perf_elems_q;
    assign perf_cmds  = perf_cmds_q;
`endif

endmodule

// File: tb/tb_ex_alu_sequencer.sv
// Directed self-checking bench for ex_alu_sequencer with a behavioural EX-stage ALU.
module tb_ex_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [4:0]  cmd_len;
    logic        cmd_use_imm;
    logic [31:0] cmd_imm;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] rd_data;
    logic [31:0] alu_rs1_val, alu_rs2_val, alu_imm, alu_result;
    logic        alu_use_imm;
    logic [3:0]  alu_ctrl;
    logic        busy, done, err;
`ifdef EX_SEQ_PERF_EN
    logic [31:0] perf_elems, perf_cmds;
`endif

    int n_checks;
    int n_fail;

    ex_alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_src_a   (cmd_src_a),
        .cmd_src_b   (cmd_src_b),
        .cmd_dst     (cmd_dst),
        .cmd_len     (cmd_len),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rd_data     (rd_data),
        .alu_rs1_val (alu_rs1_val),
        .alu_rs2_val (alu_rs2_val),
        .alu_use_imm (alu_use_imm),
        .alu_imm     (alu_imm),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .err         (err)
`ifdef EX_SEQ_PERF_EN
        ,
        .perf_elems  (perf_elems),
        .perf_cmds   (perf_cmds)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2x2 byte matrix product, row-major bytes, results truncated to 8 bits.
    function automatic logic [31:0] mm2(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  s;
        r = 32'h0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 8'h0;
                for (int k = 0; k < 2; k++) begin
                    s = s + a[(i*2+k)*8 +: 8] * b[(k*2+j)*8 +: 8];
                end
                r[(i*2+j)*8 +: 8] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] maxpool(input logic [31:0] a);
        logic signed [7:0] m;
        logic signed [7:0] v;
        m = a[7:0];
        for (int i = 1; i < 4; i++) begin
            v = a[i*8 +: 8];
            if (v > m) m = v;
        end
        return {24'h0, m};
    endfunction

    logic [31:0] opb;
    always_comb begin
        opb = alu_use_imm ? alu_imm : alu_rs2_val;
        case (alu_ctrl)
            4'h0: alu_result = alu_rs1_val + opb;
            4'h1: alu_result = alu_rs1_val - opb;
            4'h2: alu_result = alu_rs1_val & opb;
            4'h3: alu_result = alu_rs1_val | opb;
            4'h4: alu_result = alu_rs1_val ^ opb;
            4'h8: alu_result = alu_rs1_val[31] ? 32'h0 : alu_rs1_val;
            4'h9: alu_result = mm2(alu_rs1_val, opb);
            4'hA: alu_result = {alu_rs1_val[31:16] + opb[31:16], alu_rs1_val[15:0] + opb[15:0]};
            4'hB: alu_result = maxpool(alu_rs1_val);
            default: alu_result = 32'h0;
        endcase
    end

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic read_mem(input logic [3:0] a, output logic [31:0] d);
        ld_addr = a;
        #1;
        d = rd_data;
    endtask

    // Issues one command, returns the cycle (1 = first after acceptance) where done is seen, 0 on timeout.
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] sa, input logic [3:0] sb,
                           input logic [3:0] dst, input logic [4:0] len, input logic ui,
                           input logic [31:0] imm, output int lat, output logic busy1);
        @(negedge clk);
        cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
        cmd_len = len; cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        busy1 = busy;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got busy/done/err %b expected 000", {busy, done, err}); end
        n_checks++; if ({alu_rs1_val, alu_rs2_val, alu_imm} !== 96'h0) begin n_fail++; $display("FAIL reset_alu_vals: got %h %h %h expected zeros", alu_rs1_val, alu_rs2_val, alu_imm); end
        n_checks++; if ({alu_ctrl, alu_use_imm} !== 5'b0) begin n_fail++; $display("FAIL reset_alu_ctrl: got ctrl %h use_imm %b expected 0", alu_ctrl, alu_use_imm); end
    endtask

    task automatic test_add_imm();
        int lat; logic b1; logic [31:0] d;
        for (int i = 0; i < 4; i++) host_write(4'(i), 32'(i + 1));
        host_write(4'd12, 32'hDEAD_BEEF);
        run_cmd(4'h0, 4'd0, 4'd0, 4'd8, 5'd4, 1'b1, 32'd10, lat, b1);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL add_latency: got %0d expected 5", lat); end
        n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b expected 1", b1); end
        n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_fin_flags: got ready %b busy %b expected 0 0", cmd_ready, busy); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL add_done_pulse: got done %b ready %b expected 0 1", done, cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            read_mem(4'(8 + i), d);
            n_checks++; if (d !== 32'(11 + i)) begin n_fail++; $display("FAIL add_mem%0d: got %h expected %h", 8 + i, d, 32'(11 + i)); end
        end
        read_mem(4'd12, d);
        n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL add_overrun: got %h expected deadbeef", d); end
        n_checks++; if (alu_rs1_val !== 32'd4 || alu_imm !== 32'd10 || alu_use_imm !== 1'b1) begin
            n_fail++; $display("FAIL add_alu_hold: got rs1 %h imm %h ui %b expected 4 a 1", alu_rs1_val, alu_imm, alu_use_imm); end
    endtask

    task automatic test_matmul();
        int lat; logic b1; logic [31:0] d;
        host_write(4'd0, 32'h0403_0201);
        host_write(4'd1, 32'h0100_0001);
        run_cmd(4'h9, 4'd0, 4'd1, 4'd2, 5'd1, 1'b0, 32'h0, lat, b1);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL matmul_latency: got %0d expected 2", lat); end
        read_mem(4'd2, d);
        n_checks++; if (d !== 32'h0403_0201) begin n_fail++; $display("FAIL matmul_result: got %h expected 04030201", d); end
        n_checks++; if (alu_ctrl !== 4'h9 || alu_rs2_val !== 32'h0100_0001) begin n_fail++; $display("FAIL matmul_alu_hold: got ctrl %h rs2 %h expected 9 01000001", alu_ctrl, alu_rs2_val); end
    endtask

    task automatic test_relu_mpool();
        int lat; logic b1; logic [31:0] d;
        host_write(4'd3, 32'hFFFF_FFFF);
        run_cmd(4'h8, 4'd3, 4'd3, 4'd3, 5'd1, 1'b0, 32'h0, lat, b1);
        read_mem(4'd3, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL relu_inplace: got %h expected 00000000", d); end
        host_write(4'd4, 32'h80FF_0203);
        run_cmd(4'hB, 4'd4, 4'd4, 4'd4, 5'd1, 1'b0, 32'h0, lat, b1);
        read_mem(4'd4, d);
        n_checks++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL mpool_inplace: got %h expected 00000003", d); end
    endtask

    task automatic test_vecadd_wrap();
        int lat; logic b1; logic [31:0] d;
        host_write(4'd15, 32'hFFFF_0001);
        host_write(4'd0, 32'h0001_0001);
        host_write(4'd1, 32'h0002_0003);
        run_cmd(4'hA, 4'd15, 4'd0, 4'd15, 5'd2, 1'b0, 32'h0, lat, b1);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL vecadd_latency: got %0d expected 3", lat); end
        read_mem(4'd15, d);
        n_checks++; if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL vecadd_el0: got %h expected 00000002", d); end
        read_mem(4'd0, d);
        n_checks++; if (d !== 32'h0003_0004) begin n_fail++; $display("FAIL vecadd_el1_wrap: got %h expected 00030004", d); end
    endtask

    task automatic test_illegal_zero();
        int lat; logic b1; logic [31:0] d;
        run_cmd(4'h5, 4'd0, 4'd0, 4'd9, 5'd3, 1'b0, 32'h0, lat, b1);
        n_checks++; if (lat != 1 || b1 !== 1'b0) begin n_fail++; $display("FAIL illegal_latency: got lat %0d busy %b expected 1 0", lat, b1); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", err); end
        @(negedge clk);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: got %b expected 1", err); end
        read_mem(4'd9, d);
        n_checks++; if (d !== 32'd12) begin n_fail++; $display("FAIL illegal_nowrite: got %h expected 0000000c", d); end
        n_checks++; if (alu_ctrl !== 4'hA) begin n_fail++; $display("FAIL illegal_alu_hold: got %h expected a", alu_ctrl); end
        run_cmd(4'h0, 4'd0, 4'd0, 4'd9, 5'd0, 1'b0, 32'h0, lat, b1);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zero_len_latency: got %0d expected 1", lat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_len_err_clear: got %b expected 0", err); end
        read_mem(4'd9, d);
        n_checks++; if (d !== 32'd12 || alu_ctrl !== 4'hA) begin n_fail++; $display("FAIL zero_len_nowrite: got mem %h ctrl %h expected c a", d, alu_ctrl); end
        run_cmd(4'hF, 4'd0, 4'd0, 4'd9, 5'd2, 1'b0, 32'h0, lat, b1);
        n_checks++; if (lat != 1 || err !== 1'b1) begin n_fail++; $display("FAIL illegal_opF: got lat %0d err %b expected 1 1", lat, err); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1; logic [31:0] d;
        host_write(4'd5, 32'd100);
        run_cmd(4'h0, 4'd5, 4'd0, 4'd6, 5'd3, 1'b1, 32'd1, lat, b1);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL chain_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 3; i++) begin
            read_mem(4'(6 + i), d);
            n_checks++; if (d !== 32'(101 + i)) begin n_fail++; $display("FAIL chain_mem%0d: got %h expected %h", 6 + i, d, 32'(101 + i)); end
        end
    endtask

    task automatic test_ldwe();
        int lat; logic [31:0] d;
        host_write(4'd0, 32'h0);
        host_write(4'd1, 32'h50);
        host_write(4'd13, 32'h55);
        @(negedge clk);
        cmd_op = 4'h0; cmd_src_a = 4'd0; cmd_src_b = 4'd0; cmd_dst = 4'd4;
        cmd_len = 5'd2; cmd_use_imm = 1'b1; cmd_imm = 32'd1; cmd_valid = 1'b1;
        ld_we = 1'b1; ld_addr = 4'd0; ld_data = 32'h40;
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_addr = 4'd13; ld_data = 32'hBAD0_BAD0;
        n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ldwe_run_flags: got busy %b ready %b expected 1 0", busy, cmd_ready); end
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done === 1'b1) begin lat = c; break; end
            @(negedge clk);
        end
        @(negedge clk);
        ld_we = 1'b0;
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL ldwe_latency: got %0d expected 3", lat); end
        read_mem(4'd13, d);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL ldwe_ignored: got %h expected 00000055", d); end
        read_mem(4'd4, d);
        n_checks++; if (d !== 32'h41) begin n_fail++; $display("FAIL ldwe_same_cycle: got %h expected 00000041", d); end
        read_mem(4'd5, d);
        n_checks++; if (d !== 32'h51) begin n_fail++; $display("FAIL ldwe_el1: got %h expected 00000051", d); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic done_seen;
        for (int i = 0; i < 6; i++) host_write(4'(i), 32'(i));
        for (int i = 0; i < 6; i++) host_write(4'(10 + i), 32'hA0 + 32'(i));
        @(negedge clk);
        cmd_op = 4'h0; cmd_src_a = 4'd0; cmd_src_b = 4'd0; cmd_dst = 4'd10;
        cmd_len = 5'd6; cmd_use_imm = 1'b1; cmd_imm = 32'h100; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_flags: got busy %b done %b ready %b expected 0 0 1", busy, done, cmd_ready); end
        n_checks++; if (alu_imm !== 32'h0 || alu_use_imm !== 1'b0) begin n_fail++; $display("FAIL abort_alu_reset: got imm %h ui %b expected 0 0", alu_imm, alu_use_imm); end
        done_seen = 1'b0;
        repeat (2) begin @(negedge clk); if (done === 1'b1) done_seen = 1'b1; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1; end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", done_seen); end
        for (int i = 0; i < 6; i++) begin
            read_mem(4'(10 + i), d);
            n_checks++;
            if (d !== ((i < 2) ? 32'h100 + 32'(i) : 32'hA0 + 32'(i))) begin
                n_fail++; $display("FAIL abort_mem%0d: got %h expected %h", 10 + i, d, (i < 2) ? 32'h100 + 32'(i) : 32'hA0 + 32'(i)); end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_src_a = 4'd0; cmd_src_b = 4'd0;
        cmd_dst = 4'd0; cmd_len = 5'd0; cmd_use_imm = 1'b0; cmd_imm = 32'h0;
        ld_we = 1'b0; ld_addr = 4'd0; ld_data = 32'h0;
        test_reset();
        test_add_imm();
        test_matmul();
        test_relu_mpool();
        test_vecadd_wrap();
        test_illegal_zero();
        test_back_to_back();
        test_ldwe();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
